avalon_sdr_responder: RTL
=========================

AVALON_SDR_RESPONDER -- requirements
Module: avalon_sdr_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 16-bit storage words.
REQ-002 SHALL have parameter READ_LATENCY, default 3, legal range 1..8: cycles from read acceptance to readdatavalid.
REQ-003 SHALL have parameter MAX_PENDING, default 2, legal range 1..READ_LATENCY: maximum reads in flight.
REQ-004 SHALL have parameter STALL_PERIOD, default 0: forced 1-cycle stall after every STALL_PERIOD accepted transfers; 0 disables stalls.
REQ-005 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port avs_s0_read, input, 1 bit: read request.
REQ-008 SHALL have port avs_s0_write, input, 1 bit: write request.
REQ-009 SHALL have port avs_s0_address, input, 32 bits: byte address; word index = address[31:1]; address[0] ignored.
REQ-010 SHALL have port avs_s0_writedata, input, 16 bits: write data.
REQ-011 SHALL have port avs_s0_byteenable, input, 2 bits: bit0 enables data[7:0], bit1 enables data[15:8].
REQ-012 SHALL have port avs_s0_waitrequest, output, 1 bit: command not accepted this cycle.
REQ-013 SHALL have port avs_s0_readdata, output, 16 bits: read response data.
REQ-014 SHALL have port avs_s0_readdatavalid, output, 1 bit: readdata valid this cycle.
REQ-015 SHALL have port bd_we, input, 1 bit: backdoor preload write strobe.
REQ-016 SHALL have port bd_addr, input, 32 bits: backdoor word index.
REQ-017 SHALL have port bd_data, input, 16 bits: backdoor write data, full word.
REQ-018 SHALL have port err_oor, output, 1 bit: sticky flag for an out-of-range or illegal command.
REQ-019 SHALL have port rd_count, output, 16 bits: accepted reads, wrapping modulo 2^16.
REQ-020 SHALL have port wr_count, output, 16 bits: accepted writes, wrapping modulo 2^16.

Function
REQ-021 Acceptance SHALL occur when (read or write) is high and waitrequest is low; exactly one command SHALL be accepted per cycle at most.
REQ-022 avs_s0_waitrequest SHALL be high when reset is high, OR in-flight reads == MAX_PENDING, OR the stall cycle is active; it SHALL NOT depend combinationally on read/write/address.
REQ-023 In-flight count SHALL be incremented on read acceptance and decremented on readdatavalid; a simultaneous increment and decrement SHALL leave it unchanged.
REQ-024 When STALL_PERIOD>0, a counter SHALL count accepted transfers; on the cycle following the STALL_PERIOD-th acceptance, waitrequest SHALL be high for exactly 1 cycle, and the counter SHALL then restart from 0.
REQ-025 Read data SHALL be sampled from storage in the acceptance cycle, then delayed so that readdatavalid is high exactly READ_LATENCY cycles after acceptance; responses SHALL be in order, at most one per cycle.
REQ-026 A write accepted in cycle N SHALL be visible to a read accepted in cycle N+1 or later.
REQ-027 A write SHALL update only the enabled bytes; byteenable 2'b00 SHALL be counted in wr_count but SHALL leave storage unchanged.
REQ-028 A word index >= DEPTH_WORDS SHALL make a read return 16'hDEAD and SHALL make a write be ignored; both cases SHALL set err_oor.
REQ-029 read and write both high SHALL be treated as a write only, SHALL set err_oor, and SHALL increment only wr_count.
REQ-030 readdata SHALL hold its last value when readdatavalid is low.
REQ-031 bd_we SHALL write bd_data to bd_addr in one cycle whenever bd_addr < DEPTH_WORDS, regardless of Avalon activity; an Avalon write to the same word in the same cycle SHALL win.

Reset
REQ-032 On reset the following SHALL be cleared: readdatavalid=0, readdata=0, err_oor=0, rd_count=0, wr_count=0, in-flight count=0, stall counter=0, and the read pipeline.
REQ-033 Reads in flight at reset SHALL never produce readdatavalid; storage contents SHALL be preserved through reset.
REQ-034 waitrequest SHALL be low in the first cycle after reset deasserts, unless a stall condition holds.

Verification
REQ-035 Backdoor load word 0=16'h1234; read address 0 -> readdatavalid exactly 3 cycles later, readdata=16'h1234, rd_count=1.
REQ-036 Write 16'hABCD to address 4 with byteenable 2'b01 over existing 16'h5500 -> a following read of address 4 returns 16'h55CD.
REQ-037 Assert read on consecutive cycles at addresses 0,2,4,6 with MAX_PENDING=2 -> waitrequest high when 2 reads are in flight; all 4 responses returned in order, none lost.
REQ-038 STALL_PERIOD=3, continuous writes -> waitrequest high for 1 cycle after every 3rd acceptance; wr_count matches the number of acceptances.
REQ-039 Read address 2*DEPTH_WORDS -> readdata=16'hDEAD and err_oor=1; assert read and write together -> only the write takes effect.
REQ-040 Reset asserted 1 cycle after a read is accepted -> no readdatavalid afterwards, counters=0, preloaded data still readable.

Source files
------------

// File: rtl/avalon_sdr_responder.sv
// Avalon-MM 16-bit memory responder with fixed read latency and bounded reads in flight.
// Read data appears READ_LATENCY cycles after acceptance. Writes take effect at the acceptance edge.
// waitrequest is raised by reset, by MAX_PENDING reads in flight, or by the periodic stall cycle.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   avs_s0_*              Avalon-MM slave: read/write commands, byte address, 16-bit data,
//                         byteenable, waitrequest, readdata/readdatavalid
//   bd_we/bd_addr/bd_data backdoor preload of one full word per cycle (word index)
//   err_oor               sticky: an out-of-range or read+write command was accepted
//   rd_count / wr_count   accepted reads / writes, wrapping modulo 2^16
module avalon_sdr_responder #(
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING  = 2,
    parameter int STALL_PERIOD = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        avs_s0_read,
    input  logic        avs_s0_write,
    input  logic [31:0] avs_s0_address,
    input  logic [15:0] avs_s0_writedata,
    input  logic [1:0]  avs_s0_byteenable,
    output logic        avs_s0_waitrequest,
    output logic [15:0] avs_s0_readdata,
    output logic        avs_s0_readdatavalid,
    input  logic        bd_we,
    input  logic [31:0] bd_addr,
    input  logic [15:0] bd_data,
    output logic        err_oor,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int PW   = $clog2(MAX_PENDING + 1);

    // Parameter legality, caught at elaboration.
    if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
        $error("READ_LATENCY must be in 1..8");
    end
    if (MAX_PENDING < 1 || MAX_PENDING > READ_LATENCY) begin : g_bad_pending
        $error("MAX_PENDING must be in 1..READ_LATENCY");
    end
    if (DEPTH_WORDS < 1) begin : g_bad_depth
        $error("DEPTH_WORDS must be at least 1");
    end

    // Storage carries no reset so preloaded contents survive a reset pulse.
    logic [15:0] mem [DEPTH_WORDS];

    logic [31:0]     word_idx;
    logic            in_range;
    logic [IDXW-1:0] mem_idx;
    logic            bd_in_range;
    logic [IDXW-1:0] bd_idx;

    assign word_idx    = {1'b0, avs_s0_address[31:1]};
    assign in_range    = word_idx < 32'(DEPTH_WORDS);
    assign mem_idx     = word_idx[IDXW-1:0];
    assign bd_in_range = bd_addr < 32'(DEPTH_WORDS);
    assign bd_idx      = bd_addr[IDXW-1:0];

    // Acceptance and command decode
    logic [PW-1:0] inflight;
    logic          stall_active;
    logic          cmd_acc;
    logic          wr_acc;
    logic          rd_acc;
    logic          bad_cmd;

    // Built only from registered state and reset, never from the command inputs.
    assign avs_s0_waitrequest = reset | (inflight == PW'(MAX_PENDING)) | stall_active;

    assign cmd_acc = (avs_s0_read | avs_s0_write) & ~avs_s0_waitrequest;
    // read+write together degrades to a plain write.
    assign wr_acc  = cmd_acc & avs_s0_write;
    assign rd_acc  = cmd_acc & avs_s0_read & ~avs_s0_write;
    assign bad_cmd = cmd_acc & ((avs_s0_read & avs_s0_write) | ~in_range);

    // Storage write port (Avalon + backdoor)
    logic wr_hit;
    logic bd_hit;

    assign wr_hit = wr_acc & in_range;
    // A backdoor write colliding with an accepted Avalon write is dropped whole,
    // so bytes the Avalon write did not enable keep their old value.
    assign bd_hit = bd_we & bd_in_range & ~(wr_hit & (bd_idx == mem_idx));

    always_ff @(posedge clk) begin
        if (bd_hit) begin
            mem[bd_idx] <= bd_data;
        end
        if (wr_hit) begin
            if (avs_s0_byteenable[0]) begin
                mem[mem_idx][7:0] <= avs_s0_writedata[7:0];
            end
            if (avs_s0_byteenable[1]) begin
                mem[mem_idx][15:8] <= avs_s0_writedata[15:8];
            end
        end
    end

    // Read data is sampled in the acceptance cycle; stale-by-one is impossible because
    // a write accepted earlier has already landed at its acceptance edge.
    logic [15:0] rd_sample;
    assign rd_sample = in_range ? mem[mem_idx] : 16'hDEAD;

    // Read pipeline: one valid/data stage per cycle of latency. Data only advances with
    // its valid, so the last stage holds the previous response between reads.
    logic [READ_LATENCY-1:0] pipe_vld;
    logic [15:0]             pipe_dat [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                pipe_dat[s] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_acc;
            if (rd_acc) begin
                pipe_dat[0] <= rd_sample;
            end
            for (int s = 1; s < READ_LATENCY; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                if (pipe_vld[s-1]) begin
                    pipe_dat[s] <= pipe_dat[s-1];
                end
            end
        end
    end

    assign avs_s0_readdatavalid = pipe_vld[READ_LATENCY-1];
    assign avs_s0_readdata      = pipe_dat[READ_LATENCY-1];

    // Reads in flight: accepted but response not yet delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({rd_acc, avs_s0_readdatavalid})
                2'b10:   inflight <= inflight + PW'(1);
                2'b01:   inflight <= inflight - PW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Periodic stall: after every STALL_PERIOD-th accepted transfer, one cycle of waitrequest.
    if (STALL_PERIOD > 0) begin : g_stall
        localparam int SW = $clog2(STALL_PERIOD + 1);
        logic [SW-1:0] xfer_cnt;
        logic          last_xfer;

        assign last_xfer = (xfer_cnt == SW'(STALL_PERIOD - 1));

        always_ff @(posedge clk) begin
            if (reset) begin
                xfer_cnt     <= '0;
                stall_active <= 1'b0;
            end else begin
                stall_active <= cmd_acc & last_xfer;
                if (cmd_acc) begin
                    xfer_cnt <= last_xfer ? '0 : xfer_cnt + SW'(1);
                end
            end
        end
    end else begin : g_no_stall
        assign stall_active = 1'b0;
    end

    // Status: sticky error flag and wrapping transfer counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_oor  <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (bad_cmd) begin
                err_oor <= 1'b1;
            end
            if (rd_acc) begin
                rd_count <= rd_count + 16'd1;
            end
            if (wr_acc) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

endmodule
